// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the async FIFO read-side packer.
// Optional feature macro: RD_PACK_TIMEOUT_EN (enables partial-beat flush).
package fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DATA_WIDTH_DEF = 8;
  localparam int RATIO_DEF      = 4;
  localparam int TIMEOUT_DEF    = 16;
  localparam int LCW            = clog2(RATIO_DEF);

endpackage

// File: rtl/rd_pack_timer.sv
// Idle counter for the read packer; saturates at TIMEOUT-1.
// Used only when RD_PACK_TIMEOUT_EN is defined.
module rd_pack_timer
  import fifo_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic rclk,
  input  logic rrst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = clog2(TIMEOUT + 1);

  logic [TW-1:0] idle;

  assign expire = (idle == TW'(TIMEOUT - 1));

  // count idle cycles, hold once expired until cleared
  always_ff @(posedge rclk) begin
    if (rrst || clr)
      idle <= '0;
    else if (en && !expire)
      idle <= idle + 1'b1;
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words and packs RATIO of them into one valid/ready beat.
// Optional feature macro: RD_PACK_TIMEOUT_EN (flush partial beat on idle).
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int RATIO      = RATIO_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                        rclk,
  input  logic                        rrst,
  input  logic                        rempty,
  input  logic [data_width-1:0]       rdata,
  output logic                        rinc,
  output logic [data_width*RATIO-1:0] m_data,
  output logic [RATIO-1:0]            m_keep,
  output logic                        m_valid,
  input  logic                        m_ready
);

  localparam int LW = clog2(RATIO);
  localparam logic [LW-1:0] LAST = LW'(RATIO - 1);

  if (RATIO < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("fifo_rd_packer: RATIO >= 2 and TIMEOUT >= 1 required");
  end

  logic [LW-1:0] cnt;
  logic [RATIO-1:0][data_width-1:0] acc;
  logic [RATIO-1:0][data_width-1:0] full_beat;
  logic [RATIO-1:0][data_width-1:0] part_beat;
  logic [RATIO-1:0] part_keep;
  logic last;
  logic slot_free;
  logic stall;
  logic pop;
  logic flush;

  assign last      = (cnt == LAST);
  assign slot_free = !m_valid || m_ready;
  assign stall     = last && m_valid && !m_ready;
  assign pop       = !rrst && !rempty && !stall;
  assign rinc      = pop;

  // candidate beats: completed (with head word) and zero-padded partial
  always_comb begin
    full_beat      = acc;
    full_beat[cnt] = rdata;
    part_beat      = '0;
    part_keep      = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i < int'(cnt)) begin
        part_beat[i] = acc[i];
        part_keep[i] = 1'b1;
      end
    end
  end

`ifdef RD_PACK_TIMEOUT_EN
  logic expire;

  rd_pack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .rclk   (rclk),
    .rrst   (rrst),
    .clr    (pop || flush),
    .en     ((cnt != '0) && !pop),
    .expire (expire)
  );

  assign flush = expire && slot_free && !pop && (cnt != '0);
`else
  assign flush = 1'b0;
`endif

  // accumulator lanes and lane counter
  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt <= '0;
      acc <= '0;
    end else if (pop) begin
      acc[cnt] <= rdata;
      cnt      <= last ? '0 : cnt + 1'b1;
    end else if (flush) begin
      cnt <= '0;
    end
  end

  // output slot: load on completion or flush, drop after handshake
  always_ff @(posedge rclk) begin
    if (rrst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
    end else if (pop && last) begin
      m_valid <= 1'b1;
      m_data  <= full_beat;
      m_keep  <= '1;
    end else if (flush) begin
      m_valid <= 1'b1;
      m_data  <= part_beat;
      m_keep  <= part_keep;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer (data_width=8, RATIO=4).
// Follows RD_PACK_TIMEOUT_EN if the design is built with it.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int TO = 16;
  localparam int NB = 1000;

  logic          clk;
  logic          rrst;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic [31:0]   m_data;
  logic [R-1:0]  m_keep;
  logic          m_valid;
  logic          m_ready;

  int checks;
  int errors;

  fifo_rd_packer #(
    .data_width (DW),
    .RATIO      (R),
    .TIMEOUT    (TO)
  ) dut (
    .rclk    (clk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        emp;
    logic [7:0]  dat;
    logic        rdy;
    logic        e_rinc;
    logic        e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
    logic        chk;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rrst    = 1'b1;
    rempty  = 1'b1;
    m_ready = 1'b0;
    step();
    rrst = 1'b0;
  endtask

  // random-run reference state
  logic [7:0]  src[NB];
  logic [7:0]  pend[$];
  logic [31:0] mbeat;
  logic [3:0]  mkeep;
  logic        mfull;
  logic        exp_pop;
  int          sidx;
  int          got;
  int          idle;
  int          cyc;

  function automatic logic [31:0] pack_pend();
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < pend.size(); i++)
      b[8*i +: 8] = pend[i];
    return b;
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    rrst    = 1'b1;
    rempty  = 1'b0;
    rdata   = 8'h5A;
    m_ready = 1'b0;

    // reset rows then a 4-word stream
    tv[0] = '{1, 0, 8'h5A, 0, 0, 0, 32'h0, 4'h0, 1};
    tv[1] = '{1, 0, 8'h5A, 0, 0, 0, 32'h0, 4'h0, 1};
    tv[2] = '{1, 0, 8'h5A, 0, 0, 0, 32'h0, 4'h0, 1};
    tv[3] = '{0, 0, 8'h11, 1, 1, 0, 32'h0, 4'h0, 0};
    tv[4] = '{0, 0, 8'h22, 1, 1, 0, 32'h0, 4'h0, 0};
    tv[5] = '{0, 0, 8'h33, 1, 1, 0, 32'h0, 4'h0, 0};
    tv[6] = '{0, 0, 8'h44, 1, 1, 1, 32'h44332211, 4'hF, 1};
    tv[7] = '{0, 1, 8'h00, 1, 0, 0, 32'h0, 4'h0, 0};

    for (int i = 0; i < 8; i++) begin
      rrst    = tv[i].rst;
      rempty  = tv[i].emp;
      rdata   = tv[i].dat;
      m_ready = tv[i].rdy;
      #2;
      chk($sformatf("tv%0d rinc", i), 32'(rinc), 32'(tv[i].e_rinc));
      step();
      chk($sformatf("tv%0d valid", i), 32'(m_valid), 32'(tv[i].e_valid));
      if (tv[i].chk) begin
        chk($sformatf("tv%0d data", i), m_data, tv[i].e_data);
        chk($sformatf("tv%0d keep", i), 32'(m_keep), 32'(tv[i].e_keep));
      end
    end

    // backpressure: pops continue until the last lane would complete
    do_reset();
    rempty  = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rdata = 8'(8'h11 * (i + 1));
      #2;
      chk($sformatf("bp pop%0d rinc", i), 32'(rinc), 32'd1);
      step();
      if (i == 3) begin
        chk("bp beat1 valid", 32'(m_valid), 32'd1);
        chk("bp beat1 data", m_data, 32'h44332211);
      end
    end
    rdata = 8'h88;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp stall rinc", 32'(rinc), 32'd0);
      step();
      chk("bp hold valid", 32'(m_valid), 32'd1);
      chk("bp hold data", m_data, 32'h44332211);
      chk("bp hold keep", 32'(m_keep), 32'hF);
    end
    m_ready = 1'b1;
    #2;
    chk("bp release rinc", 32'(rinc), 32'd1);
    step();
    chk("bp beat2 valid", 32'(m_valid), 32'd1);
    chk("bp beat2 data", m_data, 32'h88776655);
    rempty = 1'b1;
    step();
    chk("bp drain valid", 32'(m_valid), 32'd0);

    // partial beat then long idle
    do_reset();
    m_ready = 1'b1;
    rempty  = 1'b0;
    rdata   = 8'hAA;
    step();
    rdata = 8'hBB;
    step();
    rempty = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
`ifdef RD_PACK_TIMEOUT_EN
      chk($sformatf("idle%0d valid", k), 32'(m_valid), 32'(k == TO));
      if (k == TO) begin
        chk("flush data", m_data, 32'h0000BBAA);
        chk("flush keep", 32'(m_keep), 32'h3);
      end
`else
      chk($sformatf("idle%0d valid", k), 32'(m_valid), 32'd0);
`endif
    end

    // reset mid-beat discards stale lanes
    do_reset();
    m_ready = 1'b1;
    rempty  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdata = 8'(8'hA1 + i);
      step();
    end
    rrst = 1'b1;
    #2;
    chk("mid rst rinc", 32'(rinc), 32'd0);
    step();
    chk("mid rst valid", 32'(m_valid), 32'd0);
    rrst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rdata = 8'(i + 1);
      step();
    end
    chk("post rst valid", 32'(m_valid), 32'd1);
    chk("post rst data", m_data, 32'h04030201);
    chk("post rst keep", 32'(m_keep), 32'hF);

    // random traffic against a queue-based reference
    do_reset();
    for (int i = 0; i < NB; i++) src[i] = 8'($urandom);
    pend.delete();
    mfull = 1'b0;
    mbeat = '0;
    mkeep = '0;
    sidx  = 0;
    got   = 0;
    idle  = 0;
    cyc   = 0;
    while (cyc < 20000 && got < NB / R) begin
      rempty  = (sidx >= NB) || ($urandom_range(0, 9) < 3);
      rdata   = rempty ? 8'($urandom) : src[sidx];
      m_ready = ($urandom_range(0, 9) < 6);
      #2;
      exp_pop = !rempty &&
                !(pend.size() == R - 1 && mfull && !m_ready);
      chk("rnd rinc", 32'(rinc), 32'(exp_pop));
      chk("rnd valid", 32'(m_valid), 32'(mfull));
      if (mfull) begin
        chk("rnd data", m_data, mbeat);
        chk("rnd keep", 32'(m_keep), 32'(mkeep));
      end
      if (mfull && m_ready) begin
        mfull = 1'b0;
        got++;
      end
      if (exp_pop) begin
        pend.push_back(rdata);
        sidx++;
        idle = 0;
        if (pend.size() == R) begin
          mbeat = pack_pend();
          mkeep = 4'hF;
          mfull = 1'b1;
          pend.delete();
        end
      end else if (pend.size() != 0) begin
`ifdef RD_PACK_TIMEOUT_EN
        if (idle >= TO - 1 && !mfull) begin
          mbeat = pack_pend();
          mkeep = 4'((1 << pend.size()) - 1);
          mfull = 1'b1;
          pend.delete();
          idle = 0;
        end else if (idle < TO - 1) begin
          idle++;
        end
`endif
      end
      step();
      cyc++;
    end
    chk("rnd beats done", 32'(got), 32'(NB / R));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
